// File: rtl/spaceship_controls.sv
// spaceship_controls: turns PS/2 scan bytes into a held-key movement code
// and a rate-limited, frame-aligned fire pulse for the missile logic.
module spaceship_controls #(
    parameter logic [7:0]  LEFT_CODE     = 8'h6B,
    parameter logic [7:0]  RIGHT_CODE    = 8'h74,
    parameter logic [7:0]  FIRE_CODE     = 8'h29,
    parameter int unsigned FIRE_COOLDOWN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din_valid,
    input  logic [7:0] din,
    input  logic       startOfFrame,
    output logic [1:0] X_direction,
    output logic       fire_pulse,
    output logic       protocol_err
);

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [1:0] DIR_NONE  = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd2;
    localparam logic [7:0] CD_LOAD   = 8'(FIRE_COOLDOWN);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} pfx_t;

    pfx_t       state_q, state_d;
    logic       left_held_q, left_held_d;
    logic       right_held_q, right_held_d;
    logic       fire_held_q, fire_held_d;
    logic       last_right_q, last_right_d;   // 0 = left pressed last
    logic       fire_pending_q, fire_pending_d;
    logic [7:0] cooldown_q, cooldown_d;
    logic [1:0] xdir_q, xdir_d;
    logic       pulse_q, pulse_d;
    logic       perr_q, perr_d;

    logic       done, ext, brk;
    logic       is_left, is_right, is_fire;

    // Prefix tracking, key state, fire scheduling and next output values
    always_comb begin
        state_d        = state_q;
        left_held_d    = left_held_q;
        right_held_d   = right_held_q;
        fire_held_d    = fire_held_q;
        last_right_d   = last_right_q;
        fire_pending_d = fire_pending_q;
        cooldown_d     = cooldown_q;
        pulse_d        = 1'b0;
        perr_d         = 1'b0;
        done           = 1'b0;
        ext            = (state_q == S_EXT) || (state_q == S_EXT_BRK);
        brk            = (state_q == S_BRK) || (state_q == S_EXT_BRK);

        if (din_valid) begin
            if (din == PFX_EXT) begin
                // Repeated E0 is tolerated; E0 after a break prefix is not
                state_d = S_EXT;
                perr_d  = brk;
            end else if (din == PFX_BRK) begin
                state_d = ext ? S_EXT_BRK : S_BRK;
                perr_d  = brk;
            end else begin
                state_d = S_IDLE;
                done    = 1'b1;
            end
        end

        is_left  = done &&  ext && (din == LEFT_CODE);
        is_right = done &&  ext && (din == RIGHT_CODE);
        is_fire  = done && !ext && (din == FIRE_CODE);

        // Frame tick: launch a pending shot or run the cooldown down
        if (startOfFrame) begin
            if (fire_pending_q) begin
                pulse_d        = 1'b1;
                fire_pending_d = 1'b0;
                cooldown_d     = CD_LOAD;
            end else if (cooldown_q != 8'd0) begin
                cooldown_d = cooldown_q - 8'd1;
            end
        end

        // Typematic repeats of a held key change nothing
        if (is_left) begin
            if (brk) begin
                left_held_d = 1'b0;
            end else if (!left_held_q) begin
                left_held_d  = 1'b1;
                last_right_d = 1'b0;
            end
        end
        if (is_right) begin
            if (brk) begin
                right_held_d = 1'b0;
            end else if (!right_held_q) begin
                right_held_d = 1'b1;
                last_right_d = 1'b1;
            end
        end
        // A press while a shot is already pending merges into it, so a
        // press in the launching cycle cannot sneak past the cooldown.
        if (is_fire) begin
            if (brk) begin
                fire_held_d = 1'b0;
            end else if (!fire_held_q) begin
                fire_held_d = 1'b1;
                if (cooldown_q == 8'd0 && !fire_pending_q)
                    fire_pending_d = 1'b1;
            end
        end

        unique case ({left_held_d, right_held_d})
            2'b10:   xdir_d = DIR_LEFT;
            2'b01:   xdir_d = DIR_RIGHT;
            2'b11:   xdir_d = last_right_d ? DIR_RIGHT : DIR_LEFT;
            default: xdir_d = DIR_NONE;
        endcase
    end

    // All state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            left_held_q    <= 1'b0;
            right_held_q   <= 1'b0;
            fire_held_q    <= 1'b0;
            last_right_q   <= 1'b0;
            fire_pending_q <= 1'b0;
            cooldown_q     <= 8'd0;
            xdir_q         <= DIR_NONE;
            pulse_q        <= 1'b0;
            perr_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            left_held_q    <= left_held_d;
            right_held_q   <= right_held_d;
            fire_held_q    <= fire_held_d;
            last_right_q   <= last_right_d;
            fire_pending_q <= fire_pending_d;
            cooldown_q     <= cooldown_d;
            xdir_q         <= xdir_d;
            pulse_q        <= pulse_d;
            perr_q         <= perr_d;
        end
    end

    assign X_direction  = xdir_q;
    assign fire_pulse   = pulse_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_spaceship_controls.sv
// Self-checking bench for spaceship_controls: expectations are queued as
// stimulus is driven; observed {X_direction, protocol_err, fire_pulse}
// vectors are queued when sampled and the two are matched in order.
module tb_spaceship_controls;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din_valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic       startOfFrame = 1'b0;
    logic [1:0] X_direction;
    logic       fire_pulse;
    logic       protocol_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      nm;
        logic [3:0] v;   // {X_direction, protocol_err, fire_pulse}
    } ent_t;

    ent_t       exp_q[$];
    logic [3:0] obs_q[$];
    ent_t       e;
    logic [3:0] o;

    spaceship_controls dut (
        .clk          (clk),
        .reset        (reset),
        .din_valid    (din_valid),
        .din          (din),
        .startOfFrame (startOfFrame),
        .X_direction  (X_direction),
        .fire_pulse   (fire_pulse),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    // One scan byte; sample one cycle after the strobe
    task automatic step_byte(input logic [7:0] b, input logic [1:0] x,
                             input logic err, input string nm);
        exp_q.push_back('{nm, {x, err, 1'b0}});
        @(negedge clk);
        din = b; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        obs_q.push_back({X_direction, protocol_err, fire_pulse});
    endtask

    // One startOfFrame pulse; sample the cycle after it
    task automatic step_frame(input logic [1:0] x, input logic p, input string nm);
        exp_q.push_back('{nm, {x, 1'b0, p}});
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        obs_q.push_back({X_direction, protocol_err, fire_pulse});
    endtask

    // Scan byte and startOfFrame in the same cycle
    task automatic step_both(input logic [7:0] b, input logic [1:0] x,
                             input logic p, input string nm);
        exp_q.push_back('{nm, {x, 1'b0, p}});
        @(negedge clk);
        din = b; din_valid = 1'b1; startOfFrame = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; startOfFrame = 1'b0;
        obs_q.push_back({X_direction, protocol_err, fire_pulse});
    endtask

    // Quiet cycle; checks that pulses have dropped
    task automatic step_idle(input logic [1:0] x, input string nm);
        exp_q.push_back('{nm, {x, 2'b00}});
        @(negedge clk);
        obs_q.push_back({X_direction, protocol_err, fire_pulse});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        din_valid = 1'b0; startOfFrame = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back('{"reset_state", 4'b0000});
        obs_q.push_back({X_direction, protocol_err, fire_pulse});
        reset = 1'b0;
        step_idle(2'd0, "post_reset_idle");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'bxxxx;
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got x=%0d err=%b pulse=%b, expected x=%0d err=%b pulse=%b",
                         e.nm, o[3:2], o[1], o[0], e.v[3:2], e.v[1], e.v[0]);
            end
        end
    endtask

    task automatic test_left();
        step_byte(8'hE0, 2'd0, 1'b0, "left_pfx");
        step_byte(8'h6B, 2'd1, 1'b0, "left_make");
        step_byte(8'hE0, 2'd1, 1'b0, "left_brk_e0");
        step_byte(8'hF0, 2'd1, 1'b0, "left_brk_f0");
        step_byte(8'h6B, 2'd0, 1'b0, "left_break");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'bxxxx;
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got x=%0d err=%b pulse=%b, expected x=%0d err=%b pulse=%b",
                         e.nm, o[3:2], o[1], o[0], e.v[3:2], e.v[1], e.v[0]);
            end
        end
    endtask

    task automatic test_last_pressed();
        step_byte(8'hE0, 2'd0, 1'b0, "lp_e0_a");
        step_byte(8'h6B, 2'd1, 1'b0, "lp_left");
        step_byte(8'hE0, 2'd1, 1'b0, "lp_e0_b");
        step_byte(8'h74, 2'd2, 1'b0, "lp_right_wins");
        step_byte(8'hE0, 2'd2, 1'b0, "lp_e0_c");
        step_byte(8'h6B, 2'd2, 1'b0, "lp_typematic_left");
        step_byte(8'hE0, 2'd2, 1'b0, "lp_e0_d");
        step_byte(8'hF0, 2'd2, 1'b0, "lp_f0_d");
        step_byte(8'h74, 2'd1, 1'b0, "lp_right_release");
        step_byte(8'hE0, 2'd1, 1'b0, "lp_e0_e");
        step_byte(8'hF0, 2'd1, 1'b0, "lp_f0_e");
        step_byte(8'h6B, 2'd0, 1'b0, "lp_left_release");
        step_byte(8'hE0, 2'd0, 1'b0, "lp_e0_f");
        step_byte(8'hE0, 2'd0, 1'b0, "lp_double_e0_ok");
        step_byte(8'h74, 2'd2, 1'b0, "lp_right_after_e0e0");
        step_byte(8'hE0, 2'd2, 1'b0, "lp_e0_g");
        step_byte(8'hF0, 2'd2, 1'b0, "lp_f0_g");
        step_byte(8'h74, 2'd0, 1'b0, "lp_right_off");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'bxxxx;
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got x=%0d err=%b pulse=%b, expected x=%0d err=%b pulse=%b",
                         e.nm, o[3:2], o[1], o[0], e.v[3:2], e.v[1], e.v[0]);
            end
        end
    endtask

    task automatic test_ignored();
        step_byte(8'h6B, 2'd0, 1'b0, "ign_keypad4");
        step_byte(8'hE0, 2'd0, 1'b0, "ign_e0");
        step_byte(8'h29, 2'd0, 1'b0, "ign_e0_29");
        step_byte(8'hF0, 2'd0, 1'b0, "ign_f0");
        step_byte(8'h6B, 2'd0, 1'b0, "ign_break_unheld");
        step_frame(2'd0, 1'b0, "ign_no_fire");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'bxxxx;
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got x=%0d err=%b pulse=%b, expected x=%0d err=%b pulse=%b",
                         e.nm, o[3:2], o[1], o[0], e.v[3:2], e.v[1], e.v[0]);
            end
        end
    endtask

    task automatic test_fire();
        step_byte(8'h29, 2'd0, 1'b0, "fire_press");
        step_idle(2'd0, "fire_wait_frame");
        step_frame(2'd0, 1'b1, "fire_pulse_frame0");           // cooldown 8
        step_idle(2'd0, "fire_pulse_one_cycle");
        step_byte(8'h29, 2'd0, 1'b0, "fire_typematic");
        step_frame(2'd0, 1'b0, "fire_no_retrigger_f1");        // 7
        step_byte(8'hF0, 2'd0, 1'b0, "fire_rel_f0_a");
        step_byte(8'h29, 2'd0, 1'b0, "fire_rel_a");
        step_frame(2'd0, 1'b0, "fire_f2");                     // 6
        step_frame(2'd0, 1'b0, "fire_f3");                     // 5
        step_byte(8'h29, 2'd0, 1'b0, "fire_press_f3_drop");
        step_byte(8'hF0, 2'd0, 1'b0, "fire_rel_f0_b");
        step_byte(8'h29, 2'd0, 1'b0, "fire_rel_b");
        for (int i = 4; i <= 7; i++)
            step_frame(2'd0, 1'b0, $sformatf("fire_cd_f%0d", i)); // 4..1
        step_byte(8'h29, 2'd0, 1'b0, "fire_press_cd1_drop");
        step_byte(8'hF0, 2'd0, 1'b0, "fire_rel_f0_c");
        step_byte(8'h29, 2'd0, 1'b0, "fire_rel_c");
        step_frame(2'd0, 1'b0, "fire_f8_dropped_stays");       // 0
        step_byte(8'h29, 2'd0, 1'b0, "fire_press_f9");
        step_frame(2'd0, 1'b1, "fire_pulse_f9");
        step_idle(2'd0, "fire_pulse_f9_one_cycle");
        step_byte(8'hF0, 2'd0, 1'b0, "fire_rel_f0_d");
        step_byte(8'h29, 2'd0, 1'b0, "fire_rel_d");
        for (int i = 0; i < 8; i++)
            step_frame(2'd0, 1'b0, $sformatf("fire_drain_%0d", i));
        // fire make together with startOfFrame: fires at the next frame
        step_both(8'h29, 2'd0, 1'b0, "fire_same_cycle_no_pulse");
        step_frame(2'd0, 1'b1, "fire_same_cycle_next_frame");
        step_byte(8'hF0, 2'd0, 1'b0, "fire_rel_f0_e");
        step_byte(8'h29, 2'd0, 1'b0, "fire_rel_e");
        for (int i = 0; i < 8; i++)
            step_frame(2'd0, 1'b0, $sformatf("fire_drain2_%0d", i));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'bxxxx;
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got x=%0d err=%b pulse=%b, expected x=%0d err=%b pulse=%b",
                         e.nm, o[3:2], o[1], o[0], e.v[3:2], e.v[1], e.v[0]);
            end
        end
    endtask

    task automatic test_protocol_err();
        step_byte(8'hF0, 2'd0, 1'b0, "perr_f0");
        step_byte(8'hE0, 2'd0, 1'b1, "perr_f0_e0");
        step_idle(2'd0, "perr_one_cycle");
        step_byte(8'h74, 2'd2, 1'b0, "perr_then_right");
        step_byte(8'hF0, 2'd2, 1'b0, "perr_f0_a");
        step_byte(8'hF0, 2'd2, 1'b1, "perr_f0_f0");
        step_byte(8'h6B, 2'd2, 1'b0, "perr_keypad4_break");
        step_byte(8'hE0, 2'd2, 1'b0, "perr_e0_b");
        step_byte(8'hF0, 2'd2, 1'b0, "perr_ef_b");
        step_byte(8'hF0, 2'd2, 1'b1, "perr_ef_f0");
        step_byte(8'h74, 2'd0, 1'b0, "perr_right_release");
        step_byte(8'hE0, 2'd0, 1'b0, "perr_e0_c");
        step_byte(8'hF0, 2'd0, 1'b0, "perr_ef_c");
        step_byte(8'hE0, 2'd0, 1'b1, "perr_ef_e0");
        step_byte(8'h74, 2'd2, 1'b0, "perr_ef_e0_right");
        step_byte(8'hE0, 2'd2, 1'b0, "perr_e0_d");
        step_byte(8'hF0, 2'd2, 1'b0, "perr_f0_d");
        step_byte(8'h74, 2'd0, 1'b0, "perr_cleanup");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'bxxxx;
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got x=%0d err=%b pulse=%b, expected x=%0d err=%b pulse=%b",
                         e.nm, o[3:2], o[1], o[0], e.v[3:2], e.v[1], e.v[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_byte(8'hE0, 2'd0, 1'b0, "rm_e0");
        step_byte(8'h6B, 2'd1, 1'b0, "rm_left");
        step_byte(8'h29, 2'd1, 1'b0, "rm_fire_pending");
        step_byte(8'hE0, 2'd1, 1'b0, "rm_e0_b");
        step_byte(8'hF0, 2'd1, 1'b0, "rm_f0_b");
        // asynchronous reset away from any clock edge
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        exp_q.push_back('{"rm_async_clear", 4'b0000});
        obs_q.push_back({X_direction, protocol_err, fire_pulse});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step_byte(8'h74, 2'd0, 1'b0, "rm_74_not_ext");
        step_frame(2'd0, 1'b0, "rm_pending_cleared");
        step_byte(8'h29, 2'd0, 1'b0, "rm_fire_after_reset");
        step_frame(2'd0, 1'b1, "rm_cooldown_cleared");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 4'bxxxx;
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got x=%0d err=%b pulse=%b, expected x=%0d err=%b pulse=%b",
                         e.nm, o[3:2], o[1], o[0], e.v[3:2], e.v[1], e.v[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_left();
        test_last_pressed();
        test_ignored();
        test_fire();
        test_protocol_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spaceship_controls.md
Name: spaceship_controls

Overview:
- Keyboard-side producer of the player's movement and fire commands.
- Consumes decoded PS/2 scan-code bytes from the keyboard receiver and tracks make/break prefixes plus held-key state.
- Drives the 2-bit X_direction code that the spaceship movement block samples on startOfFrame.
- Also produces a rate-limited, frame-aligned single-cycle fire pulse for the missile logic.

Parameters:
LEFT_CODE, 8'h6B, scan code of left arrow (valid only with E0 prefix)
RIGHT_CODE, 8'h74, scan code of right arrow (valid only with E0 prefix)
FIRE_CODE, 8'h29, scan code of space bar (valid only without E0 prefix)
FIRE_COOLDOWN, 8, frames after a fire pulse during which new fire presses are dropped (1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
din_valid  in  1  one-cycle strobe: din holds a new scan byte
din  in  8  scan byte from PS/2 receiver
startOfFrame  in  1  one-cycle pulse at each frame start (30Hz)
X_direction  out  2  0 = don't move, 1 = move left, 2 = move right (3 never driven)
fire_pulse  out  1  one-cycle fire request, frame aligned
protocol_err  out  1  one-cycle pulse on illegal prefix sequence

Behaviour:
- Reset (async, active-high, any time, including mid-sequence) has the following effects:
  - X_direction = 0, fire_pulse = 0, protocol_err = 0.
  - Prefix FSM returns to IDLE.
  - left_held, right_held and fire_held clear; last_dir = left.
  - fire_pending clears; cooldown counter = 0.
- Prefix FSM (advances only on din_valid):
  - States: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
  - From IDLE: E0 -> EXT; F0 -> BRK.
  - From EXT: F0 -> EXT_BRK.
  - From BRK: E0 -> EXT and protocol_err. F0 -> BRK and protocol_err.
  - From EXT: E0 -> EXT, no error. From EXT_BRK: E0 -> EXT and protocol_err.
  - From EXT_BRK: F0 -> EXT_BRK and protocol_err.
  - Any other byte completes a code with ext = (state in EXT/EXT_BRK) and brk = (state in BRK/EXT_BRK). FSM then returns to IDLE.
- Code matching:
  - Left = ext and LEFT_CODE; right = ext and RIGHT_CODE; fire = !ext and FIRE_CODE.
  - Any other completed code, e.g. 6B without E0 (keypad 4) or E0 29, is ignored with no error.
- Make (brk = 0):
  - Key not held: set held flag. For left/right, last_dir = that key.
  - Key already held (typematic repeat): no change at all. last_dir is not updated and no fire is generated.
- Break (brk = 1): clear held flag. Break of a key not held is a no-op.
- X_direction (registered; updates the cycle after the completing byte's din_valid, 1-cycle latency):
  - left_held only -> 1.
  - right_held only -> 2.
  - Neither -> 0.
  - Both -> last_dir (1 or 2).
  - Not gated by startOfFrame; the mover samples it.
- Fire:
  - Fire make with fire not held and cooldown = 0 sets fire_pending.
  - Fire make during cooldown is dropped, not queued.
  - On startOfFrame with fire_pending = 1:
    - fire_pulse = 1 the next cycle, for exactly one cycle.
    - fire_pending clears.
    - cooldown loads FIRE_COOLDOWN.
  - On startOfFrame with cooldown > 0 and no load in that cycle: cooldown decrements.
  - Holding fire never retriggers; the key must be released and pressed again.
- din_valid and startOfFrame in the same cycle: both are processed. A fire make arriving in that cycle sets pending and fires at the following startOfFrame.
- protocol_err is registered, 1-cycle latency, one-cycle pulse.

Test Plan:
- Reset, then E0 6B -> X_direction = 1 one cycle after the 6B strobe. Then E0 F0 6B -> X_direction = 0.
- E0 6B, then E0 74 -> X_direction = 2 (last pressed). Repeat E0 6B (typematic) -> X_direction stays 2. E0 F0 74 -> X_direction = 1.
- 6B without prefix, and E0 29 -> X_direction stays 0, fire_pulse never asserts, protocol_err stays 0.
- 29 mid-frame -> single fire_pulse the cycle after the next startOfFrame. Repeated 29 makes while held -> no further pulses. F0 29 then 29 at frame 3 after the pulse -> dropped (cooldown 8). Press at frame 9 -> pulse at the next startOfFrame.
- F0 E0 -> protocol_err for one cycle, FSM in EXT. Following 74 -> treated as right make, X_direction = 2.
- Reset asserted after E0 F0 (in EXT_BRK) with left held -> X_direction = 0 immediately. Next byte 74 after reset release -> non-extended, ignored. X_direction stays 0.
